// File: rtl/audio_dma_master.sv
// audio_dma_master: bus initiator that streams stereo frames from a RAM buffer to the audio sample registers.
// Optional feature macro AUDIO_DMA_LOOP_EN adds a 'loop' input for continuous circular playback.
module audio_dma_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] STATUS_ADDR    = 32'h8000_000c,
    parameter logic [31:0] LEFT_ADDR      = 32'h8000_0010,
    parameter logic [31:0] RIGHT_ADDR     = 32'h8000_0014
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] buf_addr,
    input  logic [15:0] frame_count,
`ifdef AUDIO_DMA_LOOP_EN
    input  logic        loop,
`endif
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] frames_done,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        valid,
    input  logic [31:0] rdata,
    input  logic        ready
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, RD_L, RD_R, POLL, GAP, WR_L, WR_R, NEXT} state_t;

    state_t        state, state_n, issue_st;
    logic          issue, stop_req, stop_req_n, stop_any, loop_active;
    logic          valid_n, busy_n, done_n, error_n;
    logic [31:0]   addr_n, wdata_n, ptr, ptr_n;
    logic [3:0]    wstrb_n;
    logic [15:0]   frames_done_n, remaining, remaining_n;
    logic [23:0]   sample_l, sample_l_n, sample_r, sample_r_n;
    logic [TW-1:0] tmo, tmo_n;
    logic          rdata_unused;

`ifdef AUDIO_DMA_LOOP_EN
    logic          loop_r, loop_r_n;
    logic [31:0]   base_addr, base_addr_n;
    logic [15:0]   base_count, base_count_n;
    assign loop_active = loop_r;
`else
    assign loop_active = 1'b0;
`endif

    assign rdata_unused = ^rdata[31:24];
    assign stop_any     = stop_req || (stop && state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            valid       <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            wstrb       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            frames_done <= '0;
            ptr         <= '0;
            remaining   <= '0;
            sample_l    <= '0;
            sample_r    <= '0;
            stop_req    <= 1'b0;
            tmo         <= '0;
`ifdef AUDIO_DMA_LOOP_EN
            loop_r      <= 1'b0;
            base_addr   <= '0;
            base_count  <= '0;
`endif
        end else begin
            state       <= state_n;
            valid       <= valid_n;
            addr        <= addr_n;
            wdata       <= wdata_n;
            wstrb       <= wstrb_n;
            busy        <= busy_n;
            done        <= done_n;
            error       <= error_n;
            frames_done <= frames_done_n;
            ptr         <= ptr_n;
            remaining   <= remaining_n;
            sample_l    <= sample_l_n;
            sample_r    <= sample_r_n;
            stop_req    <= stop_req_n;
            tmo         <= tmo_n;
`ifdef AUDIO_DMA_LOOP_EN
            loop_r      <= loop_r_n;
            base_addr   <= base_addr_n;
            base_count  <= base_count_n;
`endif
        end
    end

    always_comb begin
        state_n       = state;
        valid_n       = valid;
        addr_n        = addr;
        wdata_n       = wdata;
        wstrb_n       = wstrb;
        busy_n        = busy;
        done_n        = 1'b0;
        error_n       = error;
        frames_done_n = frames_done;
        ptr_n         = ptr;
        remaining_n   = remaining;
        sample_l_n    = sample_l;
        sample_r_n    = sample_r;
        stop_req_n    = stop_req || (stop && state != IDLE);
        tmo_n         = (valid && !ready) ? tmo + TW'(1) : '0;
        issue         = 1'b0;
        issue_st      = state;
`ifdef AUDIO_DMA_LOOP_EN
        loop_r_n      = loop_r;
        base_addr_n   = base_addr;
        base_count_n  = base_count;
`endif

        case (state)
            IDLE: begin
                stop_req_n = 1'b0;
                if (start) begin
                    ptr_n         = {buf_addr[31:2], 2'b00};
                    remaining_n   = frame_count;
                    frames_done_n = '0;
                    error_n       = 1'b0;
`ifdef AUDIO_DMA_LOOP_EN
                    loop_r_n      = loop;
                    base_addr_n   = {buf_addr[31:2], 2'b00};
                    base_count_n  = frame_count;
`endif
                    if (frame_count == '0) begin
                        done_n = 1'b1;
                    end else begin
                        busy_n   = 1'b1;
                        state_n  = RD_L;
                        issue    = 1'b1;
                        issue_st = RD_L;
                    end
                end
            end
            RD_L, RD_R, POLL, WR_L, WR_R: begin
                // Entry from a completion leaves valid low for one cycle; the request is raised here.
                if (valid && ready) begin
                    valid_n = 1'b0;
                    case (state)
                        RD_L:    begin sample_l_n = rdata[23:0]; state_n = RD_R; end
                        RD_R:    begin sample_r_n = rdata[23:0]; state_n = POLL; end
                        POLL:    state_n = (rdata[1] && !rdata[0]) ? WR_L : GAP;
                        WR_L:    state_n = WR_R;
                        default: state_n = NEXT;
                    endcase
                    if (stop_any && state != WR_L && state != WR_R) begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                end else if (valid) begin
                    if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        valid_n = 1'b0;
                        error_n = 1'b1;
                        busy_n  = 1'b0;
                        tmo_n   = '0;
                        state_n = IDLE;
                    end
                end else if (stop_any && state != WR_R) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    issue = 1'b1;
                end
            end
            GAP: begin
                if (stop_any) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
                    state_n  = POLL;
                    issue    = 1'b1;
                    issue_st = POLL;
                end
            end
            NEXT: begin
                frames_done_n = frames_done + 16'd1;
                ptr_n         = ptr + 32'd8;
                remaining_n   = remaining - 16'd1;
                if (remaining == 16'd1 && !loop_active) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end else if (stop_any) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end else begin
`ifdef AUDIO_DMA_LOOP_EN
                    if (remaining == 16'd1) begin
                        ptr_n       = base_addr;
                        remaining_n = base_count;
                    end
`endif
                    state_n  = RD_L;
                    issue    = 1'b1;
                    issue_st = RD_L;
                end
            end
            default: state_n = IDLE;
        endcase

        if (issue) begin
            valid_n = 1'b1;
            wdata_n = '0;
            wstrb_n = '0;
            case (issue_st)
                RD_L:    addr_n = ptr_n;
                RD_R:    addr_n = ptr_n + 32'd4;
                POLL:    addr_n = STATUS_ADDR;
                WR_L:    begin addr_n = LEFT_ADDR;  wdata_n = {8'h00, sample_l}; wstrb_n = 4'b0111; end
                WR_R:    begin addr_n = RIGHT_ADDR; wdata_n = {8'h00, sample_r}; wstrb_n = 4'b0111; end
                default: addr_n = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_audio_dma_master.sv
// Self-checking bench for audio_dma_master: randomized RAM/status responder plus a frame-level transfer model.
`timescale 1ns/1ps
module tb_audio_dma_master;
    localparam int unsigned TMO  = 16;
    localparam logic [31:0] ST_A = 32'h8000_000c;
    localparam logic [31:0] L_A  = 32'h8000_0010;
    localparam logic [31:0] R_A  = 32'h8000_0014;

    logic        clk = 1'b0;
    logic        reset, start, stop, busy, done, error, valid, ready;
    logic [31:0] buf_addr, addr, wdata, rdata;
    logic [15:0] frame_count, frames_done;
    logic [3:0]  wstrb;

    always #5 clk = ~clk;

    audio_dma_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop),
        .buf_addr(buf_addr), .frame_count(frame_count),
        .busy(busy), .done(done), .error(error), .frames_done(frames_done),
        .addr(addr), .wdata(wdata), .wstrb(wstrb), .valid(valid),
        .rdata(rdata), .ready(ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [3:0]  wstrb;
        int unsigned cyc;
    } txn_t;

    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] status_q[$];
    bit          rand_status, stall, seen, prev_fire, prev_valid;
    int unsigned wait_max, wait_left, cyc;
    int unsigned done_cnt, busy_cnt, valid_cnt, gap_viol, stab_viol;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_wstrb;
    int          passed = 0;
    int          total  = 0;

    // Responder and protocol monitor; a completion is logged at the negedge where ready is raised.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            ready = 1'b0; seen = 0; prev_fire = 0; prev_valid = 0;
        end else begin
            if (done)  done_cnt++;
            if (busy)  busy_cnt++;
            if (valid) valid_cnt++;
            if (valid && prev_fire) gap_viol++;
            if (valid && prev_valid && !prev_fire &&
                (addr !== prev_addr || wdata !== prev_wdata || wstrb !== prev_wstrb)) stab_viol++;
            prev_valid = valid; prev_addr = addr; prev_wdata = wdata; prev_wstrb = wstrb;
            ready = 1'b0;
            prev_fire = 0;
            if (valid && !stall) begin
                if (!seen) begin
                    seen = 1;
                    wait_left = $urandom_range(wait_max, 0);
                end
                if (wait_left == 0) begin
                    ready = 1'b1; seen = 0; prev_fire = 1;
                    if (wstrb != 4'h0) rdata = '0;
                    else if (addr == ST_A) begin
                        if (status_q.size() > 0) rdata = status_q.pop_front();
                        else if (rand_status) begin
                            int unsigned pick;
                            pick = $urandom_range(3, 0);
                            rdata = (pick == 0) ? 32'h2 : (pick == 1) ? 32'h3 : (pick == 2) ? 32'h0 : $urandom;
                        end else rdata = 32'h2;
                    end else rdata = mem.exists(addr) ? mem[addr] : 32'h0BAD_0BAD;
                    log_q.push_back('{addr: addr, wdata: wdata, rdata: rdata, wstrb: wstrb, cyc: cyc});
                end else wait_left--;
            end
        end
    end

    // Frame-level model: two RAM reads, then LEFT/RIGHT writes of the low 24 bits, per frame.
    function automatic void build_expected(input logic [31:0] base, input int unsigned n);
        logic [31:0] p;
        exp_q.delete();
        for (int unsigned i = 0; i < n; i++) begin
            p = (base & ~32'h3) + 32'(8 * i);
            exp_q.push_back('{addr: p,         wdata: '0, rdata: '0, wstrb: 4'h0, cyc: 0});
            exp_q.push_back('{addr: p + 32'd4, wdata: '0, rdata: '0, wstrb: 4'h0, cyc: 0});
            exp_q.push_back('{addr: L_A, wdata: {8'h00, mem[p][23:0]},         rdata: '0, wstrb: 4'h7, cyc: 0});
            exp_q.push_back('{addr: R_A, wdata: {8'h00, mem[p + 32'd4][23:0]}, rdata: '0, wstrb: 4'h7, cyc: 0});
        end
    endfunction

    function automatic int first_mismatch();
        txn_t d[$];
        int   n;
        foreach (log_q[i]) if (!(log_q[i].addr == ST_A && log_q[i].wstrb == 4'h0)) d.push_back(log_q[i]);
        n = (d.size() > exp_q.size()) ? d.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i >= d.size() || i >= exp_q.size()) return i;
            if (d[i].addr !== exp_q[i].addr || d[i].wstrb !== exp_q[i].wstrb ||
                (exp_q[i].wstrb != 4'h0 && d[i].wdata !== exp_q[i].wdata)) return i;
        end
        return -1;
    endfunction

    // Status reads only between RD_R and WR_L; only the last of a run may be the ready pattern.
    function automatic int status_errors();
        int k = 0;
        int errs = 0;
        bit polled = 0, good = 0;
        foreach (log_q[i]) begin
            if (log_q[i].addr == ST_A && log_q[i].wstrb == 4'h0) begin
                if (k % 4 != 2 || good) errs++;
                polled = 1;
                good = log_q[i].rdata[1] && !log_q[i].rdata[0];
            end else begin
                if (k % 4 == 2) begin
                    if (!(polled && good)) errs++;
                    polled = 0; good = 0;
                end
                k++;
            end
        end
        return errs;
    endfunction

    task automatic clear_stats();
        log_q.delete();
        done_cnt = 0; busy_cnt = 0; valid_cnt = 0; gap_viol = 0; stab_viol = 0;
    endtask

    task automatic start_run(input logic [31:0] base, input logic [15:0] n);
        @(negedge clk);
        start = 1'b1; buf_addr = base; frame_count = n;
        @(negedge clk);
        start = 1'b0; buf_addr = $urandom; frame_count = 16'($urandom);
    endtask

    task automatic wait_idle(input int unsigned budget, output bit ok);
        ok = 0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        @(negedge clk);
    endtask

    task automatic fill_mem(input logic [31:0] base, input int unsigned n);
        mem.delete();
        for (int unsigned i = 0; i < 2 * n; i++) mem[(base & ~32'h3) + 32'(4 * i)] = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; stop = 0; buf_addr = '0; frame_count = '0;
        stall = 0; rand_status = 0; wait_max = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({valid, busy, done, error, wstrb} !== 8'h00 || addr !== '0 || wdata !== '0 || frames_done !== '0) begin
            $display("FAIL reset_values: valid=%b busy=%b done=%b error=%b wstrb=%h addr=%h wdata=%h fd=%0d, expected all zero",
                     valid, busy, done, error, wstrb, addr, wdata, frames_done);
        end else passed++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (valid !== 1'b0 || busy !== 1'b0) $display("FAIL idle_after_reset: valid=%b busy=%b, expected 0 0", valid, busy);
        else passed++;
    endtask

    task automatic test_basic();
        bit ok; int m;
        mem.delete();
        mem[32'h0001_0000] = 32'h0012_3456; mem[32'h0001_0004] = 32'h00AB_CDEF;
        mem[32'h0001_0008] = 32'h0000_0001; mem[32'h0001_000c] = 32'h0000_0002;
        clear_stats();
        start_run(32'h0001_0000, 16'd2);
        wait_idle(200, ok);
        total++; if (!ok) $display("FAIL basic_finish: busy still high after 200 cycles"); else passed++;
        build_expected(32'h0001_0000, 2);
        m = first_mismatch();
        total++; if (m != -1) $display("FAIL basic_sequence: first mismatch at transaction %0d, expected none", m); else passed++;
        total++; if (done_cnt != 1) $display("FAIL basic_done: %0d done pulses, expected 1", done_cnt); else passed++;
        total++; if (frames_done !== 16'd2) $display("FAIL basic_frames_done: got %0d, expected 2", frames_done); else passed++;
        total++; if (gap_viol != 0) $display("FAIL basic_valid_gap: %0d back-to-back valid cycles, expected 0", gap_viol); else passed++;
        total++; if (busy_cnt != 20) $display("FAIL basic_cycle_count: busy %0d cycles, expected 20", busy_cnt); else passed++;
        total++; if (error !== 1'b0) $display("FAIL basic_error: got %b, expected 0", error); else passed++;
    endtask

    task automatic test_status_poll();
        bit ok; int m; int nst = 0; int badgap = 0; int unsigned last = 0;
        fill_mem(32'h0000_2000, 1);
        status_q = '{32'h3, 32'h3, 32'h3, 32'h3, 32'h2};
        clear_stats();
        start_run(32'h0000_2000, 16'd1);
        wait_idle(200, ok);
        foreach (log_q[i]) if (log_q[i].addr == ST_A) begin
            if (nst > 0 && log_q[i].cyc - last != 2) badgap++;
            last = log_q[i].cyc; nst++;
        end
        build_expected(32'h0000_2000, 1);
        m = first_mismatch();
        total++; if (!ok) $display("FAIL poll_finish: busy still high after 200 cycles"); else passed++;
        total++; if (nst != 5) $display("FAIL poll_count: %0d status reads, expected 5", nst); else passed++;
        total++; if (badgap != 0) $display("FAIL poll_gap: %0d polls not separated by one idle cycle, expected 0", badgap); else passed++;
        total++; if (status_errors() != 0) $display("FAIL poll_order: %0d status ordering errors, expected 0", status_errors()); else passed++;
        total++; if (m != -1) $display("FAIL poll_sequence: first mismatch at transaction %0d, expected none", m); else passed++;
    endtask

    task automatic test_zero_frames();
        clear_stats();
        start_run(32'h0000_4000, 16'd0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) $display("FAIL zero_done: done=%b busy=%b, expected 1 0", done, busy);
        else passed++;
        repeat (6) @(negedge clk);
        total++;
        if (busy_cnt != 0 || valid_cnt != 0 || done_cnt != 1)
            $display("FAIL zero_quiet: busy cycles %0d valid cycles %0d done pulses %0d, expected 0 0 1", busy_cnt, valid_cnt, done_cnt);
        else passed++;
    endtask

    task automatic test_timeout();
        bit ok;
        fill_mem(32'h0000_6000, 1);
        stall = 1;
        clear_stats();
        start_run(32'h0000_6000, 16'd1);
        wait_idle(100, ok);
        total++; if (!ok) $display("FAIL timeout_abort: busy still high after 100 cycles"); else passed++;
        total++; if (valid_cnt != TMO) $display("FAIL timeout_length: valid high %0d cycles, expected %0d", valid_cnt, TMO); else passed++;
        total++;
        if (error !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || done_cnt != 0)
            $display("FAIL timeout_flags: error=%b busy=%b valid=%b done pulses %0d, expected 1 0 0 0", error, busy, valid, done_cnt);
        else passed++;
        stall = 0;
        clear_stats();
        start_run(32'h0000_6000, 16'd1);
        total++; if (error !== 1'b0) $display("FAIL timeout_clear: error=%b after start, expected 0", error); else passed++;
        wait_idle(200, ok);
        total++; if (!ok || done_cnt != 1) $display("FAIL timeout_recover: finished=%b done pulses %0d, expected 1 1", ok, done_cnt); else passed++;
    endtask

    task automatic test_stop();
        bit ok, found = 0; int m;
        fill_mem(32'h0000_8000, 4);
        clear_stats();
        start_run(32'h0000_8000, 16'd4);
        for (int i = 0; i < 200; i++) begin
            if (valid && addr == L_A) begin found = 1; break; end
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle(200, ok);
        build_expected(32'h0000_8000, 1);
        m = first_mismatch();
        total++; if (!found || !ok) $display("FAIL stop_reach: saw WR_L=%b returned idle=%b, expected 1 1", found, ok); else passed++;
        total++; if (m != -1) $display("FAIL stop_pairing: first mismatch at transaction %0d, expected none", m); else passed++;
        total++;
        if (frames_done !== 16'd1 || done_cnt != 0)
            $display("FAIL stop_result: frames_done=%0d done pulses %0d, expected 1 0", frames_done, done_cnt);
        else passed++;
    endtask

    task automatic test_async_reset();
        bit found = 0;
        fill_mem(32'h0000_a000, 4);
        clear_stats();
        start_run(32'h0000_a000, 16'd4);
        for (int i = 0; i < 300; i++) begin
            if (valid && addr == L_A && frames_done == 16'd1) begin found = 1; break; end
            @(negedge clk);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (!found || {valid, busy, done, error, wstrb} !== 8'h00 || addr !== '0 || wdata !== '0 || frames_done !== '0)
            $display("FAIL async_reset: found=%b valid=%b busy=%b wstrb=%h addr=%h wdata=%h fd=%0d, expected found and all zero",
                     found, valid, busy, wstrb, addr, wdata, frames_done);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        clear_stats();
        repeat (4) @(negedge clk);
        total++; if (valid_cnt != 0 || busy_cnt != 0) $display("FAIL async_reset_quiet: valid %0d busy %0d cycles, expected 0 0", valid_cnt, busy_cnt); else passed++;
    endtask

    task automatic test_random_back_to_back();
        bit ok; int m; logic [31:0] base; int unsigned n;
        rand_status = 1; wait_max = 3;
        for (int it = 0; it < 8; it++) begin
            base = (it == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
            n = $urandom_range(6, 1);
            fill_mem(base, n);
            clear_stats();
            start_run(base, 16'(n));
            repeat (2) @(negedge clk);
            start = 1'b1; buf_addr = base + 32'h100; frame_count = 16'd9;
            @(negedge clk);
            start = 1'b0;
            wait_idle(3000, ok);
            build_expected(base, n);
            m = first_mismatch();
            total++; if (!ok) $display("FAIL rand_finish[%0d]: busy still high after 3000 cycles", it); else passed++;
            total++; if (m != -1) $display("FAIL rand_sequence[%0d]: first mismatch at transaction %0d, expected none", it, m); else passed++;
            total++; if (status_errors() != 0) $display("FAIL rand_status[%0d]: %0d status ordering errors, expected 0", it, status_errors()); else passed++;
            total++;
            if (frames_done !== 16'(n) || done_cnt != 1 || error !== 1'b0)
                $display("FAIL rand_result[%0d]: frames_done=%0d done pulses %0d error=%b, expected %0d 1 0", it, frames_done, done_cnt, error, n);
            else passed++;
            total++;
            if (gap_viol != 0 || stab_viol != 0)
                $display("FAIL rand_protocol[%0d]: gap violations %0d stability violations %0d, expected 0 0", it, gap_viol, stab_viol);
            else passed++;
        end
        rand_status = 0; wait_max = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_status_poll();
        test_zero_frames();
        test_timeout();
        test_stop();
        test_async_reset();
        test_random_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/audio_dma_master.md
Name: audio_dma_master

Overview:
- Bus initiator on the CPU-side valid/ready memory bus; peripheral-side bus logic is the responder.
- Streams stereo frames from a RAM buffer to the audio sample registers, with no CPU load per sample.
- Each frame: read left word, read right word, poll audio status until ready, write left sample, write right sample.
- A CPU core or arbiter muxes this block onto the shared bus; arbitration is outside this block.

Parameters:
- TIMEOUT_CYCLES, 1024: max cycles valid may stay high without ready before abort.
- STATUS_ADDR, 32'h8000_000c: audio status register (bit0 fifo full, bit1 init done).
- LEFT_ADDR, 32'h8000_0010: left sample register.
- RIGHT_ADDR, 32'h8000_0014: right sample register; a write here pushes the FIFO.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse, begin transfer (ignored while busy)
- stop  in  1  request abort after current bus handshake
- buf_addr  in  32  RAM byte address of first frame, sampled on start; bits[1:0] forced 0
- frame_count  in  16  number of stereo frames (2 words each), sampled on start
- busy  out  1  high from cycle after accepted start until return to IDLE
- done  out  1  one-cycle pulse on normal completion
- error  out  1  sticky timeout flag, cleared on next accepted start
- frames_done  out  16  frames fully written since start
- addr  out  32  bus address
- wdata  out  32  bus write data
- wstrb  out  4  byte strobes; 0 means read
- valid  out  1  bus request
- rdata  in  32  bus read data
- ready  in  1  bus completion

Behaviour:
- Reset is asynchronous and active-high. Reset values: valid=0, addr=0, wdata=0, wstrb=0, busy=0, done=0, error=0, frames_done=0, state IDLE, internal ptr and counters 0. Reset mid-transfer drops valid immediately.
- Handshake:
  - Registered outputs.
  - addr, wdata and wstrb are stable whenever valid=1.
  - A transfer completes on the rising edge where valid&&ready.
  - valid is low for at least one cycle after every completion; the responder commits writes on every valid cycle, so valid is never held into a second transaction.
- States: IDLE, RD_L, RD_R, POLL, GAP, WR_L, WR_R, NEXT.
  - IDLE: on start, latch ptr=buf_addr&~3, remaining=frame_count, frames_done=0, error=0. If frame_count==0, pulse done next cycle, busy stays 0, no bus access. Else busy=1, go RD_L.
  - RD_L: read ptr, wstrb=0. On completion, sample_l<=rdata[23:0]; go RD_R.
  - RD_R: read ptr+4. On completion, sample_r<=rdata[23:0]; go POLL.
  - POLL: read STATUS_ADDR. On completion: if rdata[1]==1 and rdata[0]==0, go WR_L; else go GAP.
  - GAP: one idle cycle, then back to POLL.
  - WR_L: write LEFT_ADDR, wdata={8'h00,sample_l}, wstrb=4'b0111; go WR_R.
  - WR_R: write RIGHT_ADDR, wdata={8'h00,sample_r}, wstrb=4'b0111; go NEXT.
  - NEXT: frames_done+=1, ptr+=8 (32-bit wrap, no check), remaining-=1. If remaining==0, pulse done, busy=0, go IDLE; else go RD_L.
- Minimum per frame with zero-wait ready and no stalls: 10 cycles (5 transactions, each 1 valid cycle + 1 gap).
- stop: sampled any cycle while busy; latched. The in-flight handshake always completes. Return to IDLE at the next transaction boundary, no done pulse, frames_done holds its value. If stop occurs after WR_L but before WR_R, WR_R still executes so L/R stay paired.
- start and stop in the same cycle in IDLE: start accepted, stop ignored.
- Timeout: counter runs while valid=1 and ready=0. When it reaches TIMEOUT_CYCLES: drop valid, error=1, busy=0, go IDLE, no done pulse.

Optional Feature:
- Macro AUDIO_DMA_LOOP_EN.
- Defined: adds input port loop (1 bit), sampled on start. When loop=1, NEXT with remaining==0 reloads ptr=buf_addr and remaining=frame_count, and continues at RD_L. frames_done keeps counting and wraps at 16 bits. Ends only via stop or timeout; done never pulses.
- Undefined: no loop port; one-shot only.

Test Plan:
- Zero-wait RAM, status=32'h2, start, buf_addr=32'h0001_0000, frame_count=2, RAM {0x00123456,0x00ABCDEF,0x1,0x2} -> bus writes 0x8000_0010/0x00123456, 0x8000_0014/0x00ABCDEF, then 0x1/0x2; done pulses once, frames_done=2, valid low between every transaction.
- Status returns 32'h3 for 4 polls, then 32'h2 -> 5 status reads, each separated by a GAP cycle; sample writes only after the 32'h2 read.
- frame_count=0 -> done pulse one cycle after start, busy never high, valid never high.
- ready held low during RD_L, TIMEOUT_CYCLES=16 -> valid drops after 16 cycles, error=1, busy=0, no done; next start clears error.
- stop asserted during WR_L handshake, frame_count=4 -> WR_R completes, then IDLE, frames_done=1, no done pulse.
- Async reset asserted mid-WR_L -> valid=0 and all outputs at reset values the same cycle, without waiting for a clock edge.
